// File: rtl/sd_cmd_pkg.sv
// Shared types and field constants for the SD CMD-line command path.
package sd_cmd_pkg;

   localparam int unsigned SD_CMD_PAYLOAD_W = 38;
   localparam int unsigned CMD_INDEX_HI     = 37;
   localparam int unsigned CMD_INDEX_LO     = 32;
   localparam int unsigned CMD_ARG_HI       = 31;
   localparam int unsigned CMD_INDEX_W      = CMD_INDEX_HI - CMD_INDEX_LO + 1;
   localparam int unsigned CMD_ARG_W        = CMD_ARG_HI + 1;
   localparam int unsigned EDGE_CNT_W       = 8;
   localparam int unsigned ERR_CNT_W        = 8;

   typedef enum logic [2:0] {
      LISTEN   = 3'd0,
      DISPATCH = 3'd1,
      WAIT_RSP = 3'd2,
      NCR      = 3'd3,
      SEND     = 3'd4,
      DRAIN    = 3'd5,
      NRC      = 3'd6
   } state_t;

   // Decoded command as delivered by the read stream.
   typedef struct packed {
      logic [CMD_INDEX_W-1:0] index;
      logic [CMD_ARG_W-1:0]   arg;
   } sd_cmd_t;

endpackage

// File: rtl/sd_clock_edge.sv
// Synchronises a slow external clock and flags its rising edges with a one-cycle pulse.
module sd_clock_edge (
   input  logic clock,
   input  logic reset_n,
   input  logic sd_clock,
   output logic rise
);

   logic meta_q;
   logic sync_q;

   // Two-stage synchroniser; rise is high while the synchronised value has just gone 0->1.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         rise   <= 1'b0;
      end else begin
         meta_q <= sd_clock;
         sync_q <= meta_q;
         rise   <= meta_q & ~sync_q;
      end
   end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Sequences one SD command: capture, hand to application, response gaps, re-arm.
module sd_cmd_sequencer
   import sd_cmd_pkg::*;
#(
   parameter int unsigned NCR_EDGES     = 2,
   parameter int unsigned NRC_EDGES     = 8,
   parameter int unsigned TIMEOUT_EDGES = 64
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        sd_clock,
   input  logic [SD_CMD_PAYLOAD_W-1:0] rd_data,
   input  logic                        rd_strobe,
   input  logic                        rd_error,
   output logic                        rd_enable,
   output logic                        cmd_valid,
   input  logic                        cmd_ready,
   output logic [CMD_INDEX_W-1:0]      cmd_index,
   output logic [CMD_ARG_W-1:0]        cmd_arg,
   input  logic                        rsp_valid,
   input  logic                        rsp_skip,
   input  logic [SD_CMD_PAYLOAD_W-1:0] rsp_data,
   output logic                        rsp_accept,
   output logic                        wr_start,
   output logic [SD_CMD_PAYLOAD_W-1:0] wr_data,
   input  logic                        wr_busy,
   output logic                        timeout,
   output logic [ERR_CNT_W-1:0]        err_count,
   output logic                        busy
);

   localparam logic [EDGE_CNT_W-1:0] NCR_LAST = EDGE_CNT_W'(NCR_EDGES - 1);
   localparam logic [EDGE_CNT_W-1:0] NRC_LAST = EDGE_CNT_W'(NRC_EDGES - 1);
   localparam logic [EDGE_CNT_W-1:0] TMO_LAST = EDGE_CNT_W'(TIMEOUT_EDGES - 1);

   state_t                      state_q, state_d;
   logic                        rise;
   logic                        tmo_hit_c;
   logic [EDGE_CNT_W-1:0]       cnt_q, cnt_d;
   logic [ERR_CNT_W-1:0]        err_d;
   sd_cmd_t                     cmd_d;
   logic [SD_CMD_PAYLOAD_W-1:0] wr_data_d;
   logic                        rsp_accept_d;
   logic                        wr_start_d;
   logic                        timeout_d;

   sd_clock_edge u_edge (
      .clock    (clock),
      .reset_n  (reset_n),
      .sd_clock (sd_clock),
      .rise     (rise)
   );

   assign tmo_hit_c = rise && (cnt_q == TMO_LAST);

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= LISTEN;
      else          state_q <= state_d;
   end

   // Next state, edge counter, latches and pulse requests.
   always_comb begin
      state_d      = state_q;
      cnt_d        = rise ? cnt_q + 8'd1 : cnt_q;
      err_d        = err_count;
      cmd_d.index  = cmd_index;
      cmd_d.arg    = cmd_arg;
      wr_data_d    = wr_data;
      rsp_accept_d = 1'b0;
      wr_start_d   = 1'b0;
      timeout_d    = 1'b0;
      unique case (state_q)
         LISTEN: begin
            if (rd_error && (err_count != '1)) err_d = err_count + 8'd1;
            if (rd_strobe) begin
               cmd_d   = sd_cmd_t'(rd_data);
               cnt_d   = '0;
               state_d = DISPATCH;
            end
         end
         DISPATCH: begin
            if (cmd_ready) begin
               state_d = WAIT_RSP;
            end else if (tmo_hit_c) begin
               timeout_d = 1'b1;
               cnt_d     = '0;
               state_d   = NRC;
            end
         end
         WAIT_RSP: begin
            if (rsp_skip) begin
               rsp_accept_d = 1'b1;
               cnt_d        = '0;
               state_d      = NRC;
            end else if (rsp_valid) begin
               wr_data_d    = rsp_data;
               rsp_accept_d = 1'b1;
               cnt_d        = '0;
               state_d      = NCR;
            end else if (tmo_hit_c) begin
               timeout_d = 1'b1;
               cnt_d     = '0;
               state_d   = NRC;
            end
         end
         NCR: begin
            if (rise && (cnt_q == NCR_LAST)) begin
               wr_start_d = 1'b1;
               state_d    = SEND;
            end
         end
         SEND: begin
            if (wr_busy) state_d = DRAIN;
         end
         DRAIN: begin
            if (!wr_busy) begin
               cnt_d   = '0;
               state_d = NRC;
            end
         end
         NRC: begin
            if (rise && (cnt_q == NRC_LAST)) state_d = LISTEN;
         end
         default: state_d = LISTEN;
      endcase
   end

   // Registered outputs and datapath; status flags follow the state being entered.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q      <= '0;
         err_count  <= '0;
         cmd_index  <= '0;
         cmd_arg    <= '0;
         wr_data    <= '0;
         rd_enable  <= 1'b0;
         busy       <= 1'b0;
         cmd_valid  <= 1'b0;
         rsp_accept <= 1'b0;
         wr_start   <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         err_count  <= err_d;
         cmd_index  <= cmd_d.index;
         cmd_arg    <= cmd_d.arg;
         wr_data    <= wr_data_d;
         rd_enable  <= (state_d == LISTEN);
         busy       <= (state_d != LISTEN);
         cmd_valid  <= (state_d == DISPATCH);
         rsp_accept <= rsp_accept_d;
         wr_start   <= wr_start_d;
         timeout    <= timeout_d;
      end
   end

endmodule
